// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the parametrised sync FIFO.
// Default geometry, threshold defaults and a constant clog2.
package sync_fifo_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_DEPTH     = 16;
  localparam int DEF_AE_THRESH = 2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int def_af_thresh(input int depth);
    return depth - 2;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_W storage: one sync write port, one registered read port.
// Array contents are never reset; only the read register is.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // store accepted write data
  always_ff @(posedge clk_i) begin
    if (we_i) r_mem[waddr_i] <= wdata_i;
  end

  // registered read; old data wins on same-address write
  always_ff @(posedge clk_i) begin
    if (!rst_ni)   r_rdata <= '0;
    else if (re_i) r_rdata <= r_mem[raddr_i];
  end

  assign rdata_o = r_rdata;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with count, thresholds and sticky errors.
// Optional peak-occupancy output enabled by SYNC_FIFO_PEAK_EN.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = def_af_thresh(DEPTH),
  parameter int AE_THRESH = DEF_AE_THRESH,
  localparam int AW       = clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rvalid_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic [AW:0]       count_o,
  output logic              overflow_o,
  output logic              underflow_o,
`ifdef SYNC_FIFO_PEAK_EN
  input  logic              clr_err_i,
  output logic [AW:0]       peak_o
`else
  input  logic              clr_err_i
`endif
);

  localparam logic [AW:0] LP_ONE = (AW+1)'(1);
  localparam logic [AW:0] LP_AF  = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] LP_AE  = (AW+1)'(AE_THRESH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        r_rvalid;
  logic        r_ovf;
  logic        r_udf;

  logic [AW:0] w_count;
  logic        w_empty;
  logic        w_full;
  logic        w_rd_acc;
  logic        w_wr_acc;
  logic        w_ovf_evt;
  logic        w_udf_evt;

  // occupancy and flags come from registered pointers only
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);

  // a read frees a slot, so full + rd + wr accepts both
  assign w_rd_acc  = rd_en_i && !w_empty;
  assign w_wr_acc  = wr_en_i && (!w_full || w_rd_acc);
  assign w_ovf_evt = wr_en_i && !w_wr_acc;
  assign w_udf_evt = rd_en_i && w_empty;

  // advance pointers on accepted transfers; wrap bit toggles naturally
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + LP_ONE;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + LP_ONE;
    end
  end

  // one-cycle strobe marking fresh read data
  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_rvalid <= 1'b0;
    else         r_rvalid <= w_rd_acc;
  end

  // sticky errors; a same-cycle error beats the clear
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_ovf <= (r_ovf && !clr_err_i) || w_ovf_evt;
      r_udf <= (r_udf && !clr_err_i) || w_udf_evt;
    end
  end

  sync_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (w_wr_acc),
    .waddr_i (r_wr_ptr[AW-1:0]),
    .wdata_i (wdata_i),
    .re_i    (w_rd_acc),
    .raddr_i (r_rd_ptr[AW-1:0]),
    .rdata_o (rdata_o)
  );

  assign rvalid_o       = r_rvalid;
  assign full_o         = w_full;
  assign empty_o        = w_empty;
  assign almost_full_o  = (w_count >= LP_AF);
  assign almost_empty_o = (w_count <= LP_AE);
  assign count_o        = w_count;
  assign overflow_o     = r_ovf;
  assign underflow_o    = r_udf;

`ifdef SYNC_FIFO_PEAK_EN
  logic [AW:0] r_peak;

  // high-water mark, restarted from current occupancy on clear
  always_ff @(posedge clk_i) begin
    if (!rst_ni)              r_peak <= '0;
    else if (clr_err_i)       r_peak <= w_count;
    else if (w_count > r_peak) r_peak <= w_count;
  end

  assign peak_o = r_peak;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (DEPTH=16 and DEPTH=4 builds).
// Table vectors, directed corner sequences and a queue-based random model.
module tb_sync_fifo_param;

  localparam int DW  = 8;
  localparam int DEP = 16;
  localparam int AW  = 4;
  localparam int DW4 = 32;
  localparam int AW4 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, wr_en, rd_en, clr;
  logic [DW-1:0] wdata, rdata;
  logic          rvalid, full, empty, afull, aempty, ovf, udf;
  logic [AW:0]   count;

  logic           rst4_n, wr4, rd4;
  logic [DW4-1:0] wd4, rd4_data;
  logic           rv4, full4, empty4, af4, ae4, ovf4, udf4;
  logic [AW4:0]   cnt4;

`ifdef SYNC_FIFO_PEAK_EN
  logic [AW:0]  peak;
  logic [AW4:0] peak4;
`endif

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEP)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wdata_i(wdata),
    .rd_en_i(rd_en), .rdata_o(rdata), .rvalid_o(rvalid),
    .full_o(full), .empty_o(empty), .almost_full_o(afull),
    .almost_empty_o(aempty), .count_o(count), .overflow_o(ovf),
    .underflow_o(udf),
`ifdef SYNC_FIFO_PEAK_EN
    .clr_err_i(clr), .peak_o(peak)
`else
    .clr_err_i(clr)
`endif
  );

  sync_fifo_param #(.DATA_W(DW4), .DEPTH(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst4_n), .wr_en_i(wr4), .wdata_i(wd4),
    .rd_en_i(rd4), .rdata_o(rd4_data), .rvalid_o(rv4),
    .full_o(full4), .empty_o(empty4), .almost_full_o(af4),
    .almost_empty_o(ae4), .count_o(cnt4), .overflow_o(ovf4),
    .underflow_o(udf4),
`ifdef SYNC_FIFO_PEAK_EN
    .clr_err_i(1'b0), .peak_o(peak4)
`else
    .clr_err_i(1'b0)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_rd = '0;
  bit            m_rv = 0, m_ovf = 0, m_udf = 0;
  int            m_peak = 0;

  typedef struct {
    logic          rst, wr, rd, cl;
    logic [DW-1:0] wd;
    logic [19:0]   exp;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [19:0] expv(int cnt, bit rv, logic [7:0] rd,
                                       bit eo, bit eu);
    logic [4:0] c;
    c = 5'(cnt);
    return {c, cnt == DEP, cnt == 0, cnt >= DEP - 2, cnt <= 2,
            rv, rd, eo, eu};
  endfunction

  function automatic logic [19:0] actv();
    return {count, full, empty, afull, aempty, rvalid, rdata, ovf, udf};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic apply(input logic r, input logic w, input logic rd,
                       input logic c, input logic [DW-1:0] d);
    int  n;
    bit  rok, wok;
    rst_n = r; wr_en = w; rd_en = rd; clr = c; wdata = d;
    @(posedge clk);
    #1;
    if (!r) begin
      mq.delete();
      m_rd = '0; m_rv = 0; m_ovf = 0; m_udf = 0; m_peak = 0;
    end else begin
      n   = mq.size();
      rok = rd && (n > 0);
      wok = w && ((n < DEP) || rok);
      m_rv = rok;
      if (rok) m_rd = mq.pop_front();
      if (wok) mq.push_back(d);
      m_ovf  = (m_ovf && !c) || (w && !wok);
      m_udf  = (m_udf && !c) || (rd && !rok);
      m_peak = c ? n : ((n > m_peak) ? n : m_peak);
    end
  endtask

  task automatic chk_model(input string nm);
    chk(nm, 32'(actv()),
        32'(expv(mq.size(), m_rv, m_rd, m_ovf, m_udf)));
`ifdef SYNC_FIFO_PEAK_EN
    chk({nm, "_peak"}, 32'(peak), 32'(m_peak));
`endif
  endtask

  task automatic apply4(input logic w, input logic r,
                        input logic [DW4-1:0] d);
    wr4 = w; rd4 = r; wd4 = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; wr_en = 0; rd_en = 0; clr = 0; wdata = '0;
    rst4_n = 0; wr4 = 0; rd4 = 0; wd4 = '0;

    // table: reset, fill, overflow, drain, underflow, clear
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, expv(0, 0, 0, 0, 0)});
    for (int i = 1; i <= DEP; i++)
      tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 8'(i), expv(i, 0, 0, 0, 0)});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 8'h11, expv(16, 0, 0, 1, 0)});
    for (int i = 1; i <= DEP; i++)
      tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 8'h00,
                      expv(16 - i, 1, 8'(i), 1, 0)});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, expv(0, 0, 8'h10, 1, 1)});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, expv(0, 0, 8'h10, 0, 0)});

    for (int k = 0; k < tbl.size(); k++) begin
      apply(tbl[k].rst, tbl[k].wr, tbl[k].rd, tbl[k].cl, tbl[k].wd);
      chk($sformatf("tbl%0d", k), 32'(actv()), 32'(tbl[k].exp));
    end

    // empty + wr + rd: write only, read rejected
    apply(1, 1, 1, 0, 8'h55);
    chk("empty_wr_rd", 32'(actv()), 32'(expv(1, 0, 8'h10, 0, 1)));
    apply(1, 0, 1, 1, 8'h00);
    chk("read_after", 32'(actv()), 32'(expv(0, 1, 8'h55, 0, 0)));
    // clear loses to a same-cycle error
    apply(1, 0, 1, 1, 8'h00);
    chk("clr_vs_err", 32'(actv()), 32'(expv(0, 0, 8'h55, 0, 1)));
    apply(1, 0, 0, 1, 8'h00);
    chk("clr_only", 32'(actv()), 32'(expv(0, 0, 8'h55, 0, 0)));

    // full + wr + rd
    for (int i = 0; i < DEP; i++) apply(1, 1, 0, 0, 8'(8'h20 + i));
    chk_model("refill");
    apply(1, 1, 1, 0, 8'hAA);
    chk("full_wr_rd", 32'(actv()), 32'(expv(16, 1, 8'h20, 0, 0)));
    for (int i = 0; i < DEP; i++) begin
      apply(1, 0, 1, 0, 8'h00);
      chk_model("drain_aa");
    end
    chk("last_is_aa", 32'(actv()), 32'(expv(0, 1, 8'hAA, 0, 0)));

    // wrap: occupancy kept within 1..3 for 40 cycles
    apply(1, 1, 0, 0, 8'h60);
    for (int i = 0; i < 40; i++) begin
      bit w, r;
      w = (mq.size() < 3) && ($urandom_range(0, 1) == 1);
      r = (mq.size() > 1) && ($urandom_range(0, 1) == 1);
      if (!w && !r) begin
        if (mq.size() < 3) w = 1;
        else               r = 1;
      end
      apply(1, w, r, 0, 8'($urandom));
      chk_model("wrap");
    end

    // reset mid-operation beats concurrent requests
    apply(0, 1, 1, 1, 8'h77);
    chk("mid_reset", 32'(actv()), 32'(expv(0, 0, 8'h00, 0, 0)));
    chk_model("mid_reset_m");

    // randomized traffic with shifting bias
    for (int i = 0; i < 600; i++) begin
      int pw;
      pw = (i / 100) % 3 == 0 ? 80 : ((i / 100) % 3 == 1 ? 20 : 50);
      apply(1, $urandom_range(0, 99) < pw, $urandom_range(0, 99) < 50,
            $urandom_range(0, 15) == 0, 8'($urandom));
      chk_model("rand");
    end

    // DEPTH=4, DATA_W=32 instance
    apply4(0, 0, '0);
    rst4_n = 1;
    chk("d4_reset", {cnt4, empty4, rd4_data[3:0]}, {3'd0, 1'b1, 4'h0});
    for (int i = 0; i < 3; i++) apply4(1, 0, 32'hDEAD_0001 + i);
    chk("d4_count3", {cnt4, full4, af4}, {3'd3, 1'b0, 1'b1});
    for (int i = 0; i < 3; i++) begin
      apply4(0, 1, '0);
      chk("d4_drain", {rv4, rd4_data}, {1'b1, 32'hDEAD_0001 + 32'(i)});
    end
    apply4(0, 0, '0);
    chk("d4_empty", {cnt4, empty4, rv4, ovf4, udf4}, {3'd0, 4'b1000});
`ifdef SYNC_FIFO_PEAK_EN
    chk("d4_peak", 32'(peak4), 32'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
